// File: rtl/uart_tx_word.sv
// Word-oriented UART transmitter running on the bit clock: one accepted word is
// sent as NUM_BYTES consecutive frames with optional parity and inter-byte gaps.
module uart_tx_word #(
  parameter int NUM_BYTES      = 2,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int GAP_BITS       = 2,
  parameter int MSB_BYTE_FIRST = 1
) (
  input  logic                            clk_115200hz,
  input  logic                            reset,
  input  logic [NUM_BYTES*DATA_BITS-1:0]  data_in,
  input  logic                            valid,
  output logic                            ready,
  output logic                            tx,
  output logic                            busy,
  output logic                            done
);

  localparam int W       = NUM_BYTES * DATA_BITS;
  localparam int BIT_A   = (DATA_BITS > GAP_BITS) ? DATA_BITS : GAP_BITS;
  localparam int BIT_MAX = (BIT_A > 2) ? BIT_A : 2;
  localparam int BIT_W   = $clog2(BIT_MAX + 1);
  localparam int BYTE_W  = $clog2(NUM_BYTES + 1);

  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0]  GAP_LAST  = BIT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);
  localparam logic              ODD       = 1'(PARITY == 2);

  if (NUM_BYTES < 1) begin : g_bad_num_bytes
    $error("uart_tx_word: NUM_BYTES must be >= 1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_word: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_word: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_word: STOP_BITS must be 1 or 2");
  end
  if (GAP_BITS < 0) begin : g_bad_gap_bits
    $error("uart_tx_word: GAP_BITS must be >= 0");
  end
  if (MSB_BYTE_FIRST < 0 || MSB_BYTE_FIRST > 1) begin : g_bad_byte_order
    $error("uart_tx_word: MSB_BYTE_FIRST must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  // state is kept as a named signal so checkers can bind to it hierarchically
  state_t              state, state_n;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_n;
  logic [BYTE_W-1:0]   byte_cnt, byte_cnt_n;
  logic [W-1:0]        shreg, shreg_n, load_word;
  logic                par, par_n;
  logic                tx_n, ready_n, busy_n, done_n;

  // Reorder so the first byte on the line sits at the bottom; the whole word
  // then simply shifts right one bit per data cycle.
  always_comb begin
    load_word = data_in;
    if (MSB_BYTE_FIRST != 0) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        load_word[i*DATA_BITS +: DATA_BITS] = data_in[W-1-i*DATA_BITS -: DATA_BITS];
      end
    end
  end

  // tx is registered, so each branch sets the line value for the state entered
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    byte_cnt_n = byte_cnt;
    shreg_n    = shreg;
    par_n      = par;
    tx_n       = tx;
    ready_n    = ready;
    busy_n     = busy;
    done_n     = 1'b0;
    unique case (state)
      S_IDLE: begin
        tx_n    = 1'b1;
        ready_n = 1'b1;
        busy_n  = 1'b0;
        if (valid) begin
          state_n    = S_START;
          tx_n       = 1'b0;
          ready_n    = 1'b0;
          busy_n     = 1'b1;
          shreg_n    = load_word;
          bit_cnt_n  = '0;
          byte_cnt_n = '0;
        end
      end
      S_START: begin
        state_n   = S_DATA;
        bit_cnt_n = '0;
        tx_n      = shreg[0];
        par_n     = shreg[0];
        shreg_n   = shreg >> 1;
      end
      S_DATA: begin
        if (bit_cnt == DATA_LAST) begin
          bit_cnt_n = '0;
          if (PARITY != 0) begin
            state_n = S_PARITY;
            tx_n    = par ^ ODD;
          end else begin
            state_n = S_STOP;
            tx_n    = 1'b1;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
          tx_n      = shreg[0];
          par_n     = par ^ shreg[0];
          shreg_n   = shreg >> 1;
        end
      end
      S_PARITY: begin
        state_n   = S_STOP;
        bit_cnt_n = '0;
        tx_n      = 1'b1;
      end
      S_STOP: begin
        tx_n = 1'b1;
        if (bit_cnt == STOP_LAST) begin
          bit_cnt_n = '0;
          if (byte_cnt == BYTE_LAST) begin
            state_n    = S_IDLE;
            byte_cnt_n = '0;
            ready_n    = 1'b1;
            busy_n     = 1'b0;
            done_n     = 1'b1;
          end else begin
            byte_cnt_n = byte_cnt + 1'b1;
            if (GAP_BITS > 0) begin
              state_n = S_GAP;
            end else begin
              state_n = S_START;
              tx_n    = 1'b0;
            end
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      S_GAP: begin
        tx_n = 1'b1;
        if (bit_cnt == GAP_LAST) begin
          state_n   = S_START;
          bit_cnt_n = '0;
          tx_n      = 1'b0;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_115200hz or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      byte_cnt <= byte_cnt_n;
      shreg    <= shreg_n;
      par      <= par_n;
      tx       <= tx_n;
      ready    <= ready_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_word.sv
// Bench for uart_tx_word: four parameterisations share clock and reset; the
// expected line sequence is built by a small frame model into exp_q.
module tb_uart_tx_word;

  logic clk_115200hz = 1'b0;
  logic reset;
  always #5 clk_115200hz = ~clk_115200hz;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];
  logic [0:0] e;

  // defaults: 2 bytes, 8 bits, no parity, 1 stop, gap 2, MSB byte first
  logic [15:0] d_data;
  logic d_valid, d_ready, d_tx, d_busy, d_done;
  // 1 byte, even / odd parity
  logic [7:0] pe_data, po_data;
  logic pe_valid, pe_ready, pe_tx, pe_busy, pe_done;
  logic po_valid, po_ready, po_tx, po_busy, po_done;
  // 3 bytes of 7 bits, 2 stop, no gap, LSB byte first
  logic [20:0] w_data;
  logic w_valid, w_ready, w_tx, w_busy, w_done;

  uart_tx_word dut (
    .clk_115200hz(clk_115200hz), .reset(reset), .data_in(d_data), .valid(d_valid),
    .ready(d_ready), .tx(d_tx), .busy(d_busy), .done(d_done));

  uart_tx_word #(.NUM_BYTES(1), .PARITY(1)) dut_pe (
    .clk_115200hz(clk_115200hz), .reset(reset), .data_in(pe_data), .valid(pe_valid),
    .ready(pe_ready), .tx(pe_tx), .busy(pe_busy), .done(pe_done));

  uart_tx_word #(.NUM_BYTES(1), .PARITY(2)) dut_po (
    .clk_115200hz(clk_115200hz), .reset(reset), .data_in(po_data), .valid(po_valid),
    .ready(po_ready), .tx(po_tx), .busy(po_busy), .done(po_done));

  uart_tx_word #(.NUM_BYTES(3), .DATA_BITS(7), .STOP_BITS(2), .GAP_BITS(0),
                 .MSB_BYTE_FIRST(0)) dut_w (
    .clk_115200hz(clk_115200hz), .reset(reset), .data_in(w_data), .valid(w_valid),
    .ready(w_ready), .tx(w_tx), .busy(w_busy), .done(w_done));

  // frame model: start, data LSB first, optional parity, stop bits
  task automatic push_frame(input logic [8:0] b, input int db, input int par, input int stop);
    logic p;
    p = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < db; i++) begin
      exp_q.push_back(b[i]);
      p = p ^ b[i];
    end
    if (par == 1) exp_q.push_back(p);
    else if (par == 2) exp_q.push_back(~p);
    for (int i = 0; i < stop; i++) exp_q.push_back(1'b1);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
  endtask

  task automatic push_word16(input logic [15:0] w);
    push_frame({1'b0, w[15:8]}, 8, 0, 1);
    push_idle(2);
    push_frame({1'b0, w[7:0]}, 8, 0, 1);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    checks++;
    if ({d_tx, d_ready, d_busy, d_done} !== 4'b1100 || {pe_tx, pe_ready, pe_busy, pe_done} !== 4'b1100
        || {po_tx, po_ready, po_busy, po_done} !== 4'b1100 || {w_tx, w_ready, w_busy, w_done} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_outputs: got d=%b pe=%b po=%b w=%b expected 1100 each",
               {d_tx, d_ready, d_busy, d_done}, {pe_tx, pe_ready, pe_busy, pe_done},
               {po_tx, po_ready, po_busy, po_done}, {w_tx, w_ready, w_busy, w_done});
    end
    repeat (2) @(negedge clk_115200hz);
    reset = 1'b0;
  endtask

  task automatic test_basic(input logic [15:0] w, input string name);
    @(negedge clk_115200hz);
    d_data = w;
    d_valid = 1'b1;
    push_word16(w);
    @(negedge clk_115200hz);
    d_valid = 1'b0;
    for (int c = 0; c < 22; c++) begin
      if (c > 0) @(negedge clk_115200hz);
      e = exp_q.pop_front();
      checks++;
      if (d_tx !== e) begin
        errors++;
        $display("FAIL %s_tx cycle %0d: got %b expected %b", name, c, d_tx, e);
      end
      checks++;
      if ({d_ready, d_busy, d_done} !== 3'b010) begin
        errors++;
        $display("FAIL %s_flags cycle %0d: got rdy/busy/done=%b expected 010", name, c, {d_ready, d_busy, d_done});
      end
    end
    @(negedge clk_115200hz);
    checks++;
    if ({d_tx, d_ready, d_busy, d_done} !== 4'b1101) begin
      errors++;
      $display("FAIL %s_done: got tx/rdy/busy/done=%b expected 1101", name, {d_tx, d_ready, d_busy, d_done});
    end
    @(negedge clk_115200hz);
    checks++;
    if ({d_tx, d_ready, d_busy, d_done} !== 4'b1100) begin
      errors++;
      $display("FAIL %s_done_clear: got tx/rdy/busy/done=%b expected 1100", name, {d_tx, d_ready, d_busy, d_done});
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_queue: got %0d leftover expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_parity(input bit odd);
    logic t, dn;
    @(negedge clk_115200hz);
    if (odd) begin po_data = 8'h07; po_valid = 1'b1; end
    else begin pe_data = 8'h07; pe_valid = 1'b1; end
    push_frame({1'b0, 8'h07}, 8, odd ? 2 : 1, 1);
    @(negedge clk_115200hz);
    po_valid = 1'b0;
    pe_valid = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge clk_115200hz);
      e = exp_q.pop_front();
      t = odd ? po_tx : pe_tx;
      checks++;
      if (t !== e) begin
        errors++;
        $display("FAIL parity%0d_tx cycle %0d: got %b expected %b", odd, c, t, e);
      end
    end
    @(negedge clk_115200hz);
    dn = odd ? po_done : pe_done;
    checks++;
    if (dn !== 1'b1) begin
      errors++;
      $display("FAIL parity%0d_done: got %b expected 1", odd, dn);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    @(negedge clk_115200hz);
    d_data = 16'h1234;
    d_valid = 1'b1;
    push_word16(16'h1234);
    push_idle(1);
    push_word16(16'hFFFF);
    @(negedge clk_115200hz);
    d_data = 16'hFFFF;
    for (int c = 0; c < 45; c++) begin
      if (c > 0) @(negedge clk_115200hz);
      if (c == 23) d_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (d_tx !== e) begin
        errors++;
        $display("FAIL b2b_tx cycle %0d: got %b expected %b", c, d_tx, e);
      end
      if (c == 22) begin
        checks++;
        if ({d_ready, d_done} !== 2'b11) begin
          errors++;
          $display("FAIL b2b_idle_cycle: got rdy/done=%b expected 11", {d_ready, d_done});
        end
      end
    end
    @(negedge clk_115200hz);
    checks++;
    if ({d_tx, d_ready, d_done} !== 3'b111) begin
      errors++;
      $display("FAIL b2b_done: got tx/rdy/done=%b expected 111", {d_tx, d_ready, d_done});
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    @(negedge clk_115200hz);
    d_data = 16'h0000;
    d_valid = 1'b1;
    @(negedge clk_115200hz);
    d_valid = 1'b0;
    repeat (4) @(negedge clk_115200hz);
    checks++;
    if ({d_tx, d_busy} !== 2'b01) begin
      errors++;
      $display("FAIL midreset_pre: got tx/busy=%b expected 01", {d_tx, d_busy});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({d_tx, d_ready, d_busy, d_done} !== 4'b1100) begin
      errors++;
      $display("FAIL midreset_async: got tx/rdy/busy/done=%b expected 1100", {d_tx, d_ready, d_busy, d_done});
    end
    @(negedge clk_115200hz);
    reset = 1'b0;
    test_basic(16'h00FF, "after_reset");
  endtask

  task automatic test_wide;
    logic [20:0] w;
    logic [20:0] s;
    w = 21'h1ABCDE;
    s = w;
    @(negedge clk_115200hz);
    w_data = w;
    w_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_frame({2'b00, s[6:0]}, 7, 0, 2);
      s = s >> 7;
    end
    @(negedge clk_115200hz);
    w_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk_115200hz);
      if (c == 12) w_data = '0;
      e = exp_q.pop_front();
      checks++;
      if (w_tx !== e) begin
        errors++;
        $display("FAIL wide_tx cycle %0d: got %b expected %b", c, w_tx, e);
      end
    end
    @(negedge clk_115200hz);
    checks++;
    if ({w_tx, w_ready, w_busy, w_done} !== 4'b1101) begin
      errors++;
      $display("FAIL wide_done: got tx/rdy/busy/done=%b expected 1101", {w_tx, w_ready, w_busy, w_done});
    end
    exp_q.delete();
  endtask

  task automatic test_ignore_busy;
    @(negedge clk_115200hz);
    d_data = 16'hC3A1;
    d_valid = 1'b1;
    push_word16(16'hC3A1);
    @(negedge clk_115200hz);
    d_valid = 1'b0;
    for (int c = 0; c < 22; c++) begin
      if (c > 0) @(negedge clk_115200hz);
      if (c == 8) begin d_valid = 1'b1; d_data = 16'h0F0F; end
      if (c == 9) d_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (d_tx !== e) begin
        errors++;
        $display("FAIL ignore_tx cycle %0d: got %b expected %b", c, d_tx, e);
      end
    end
    @(negedge clk_115200hz);
    checks++;
    if ({d_ready, d_done} !== 2'b11) begin
      errors++;
      $display("FAIL ignore_done: got rdy/done=%b expected 11", {d_ready, d_done});
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_115200hz);
      checks++;
      if ({d_tx, d_ready, d_busy} !== 3'b110) begin
        errors++;
        $display("FAIL ignore_no_second cycle %0d: got tx/rdy/busy=%b expected 110", c, {d_tx, d_ready, d_busy});
      end
    end
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    d_data = '0;  d_valid = 1'b0;
    pe_data = '0; pe_valid = 1'b0;
    po_data = '0; po_valid = 1'b0;
    w_data = '0;  w_valid = 1'b0;
    test_reset();
    test_basic(16'hA55A, "basic");
    test_parity(1'b0);
    test_parity(1'b1);
    test_back_to_back();
    test_reset_mid_frame();
    test_wide();
    test_ignore_busy();
    test_basic(16'($urandom_range(0, 65535)), "random");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
